// File: rtl/mips_fetch_unit.sv
// Instruction fetch stage for a single-cycle MIPS datapath: local instruction
// memory, PC sequencing with jump/branch redirect, halt detection and fetch-error trap.
module mips_fetch_unit #(
  parameter int          IMEM_DEPTH = 256,
  parameter logic [31:0] RESET_PC   = 32'h00000000,
  parameter logic [31:0] HALT_WORD  = 32'hFFFFFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_en,
  input  logic [7:0]  load_addr,
  input  logic [31:0] load_data,
  input  logic        start,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] instruction,
  output logic        instr_valid,
  output logic        halted,
  output logic        fetch_error,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_e;

  localparam logic [31:0] DEPTH_W = 32'(IMEM_DEPTH);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] count_q, count_d;
  logic        fetch_error_q, fetch_error_d;

  logic [31:0] imem [IMEM_DEPTH];
  logic [31:0] rd_word;
  logic [31:0] seq_pc;
  logic [31:0] target_pc;
  logic        target_bad;
  logic        issue;

  assign rd_word  = imem[pc_q[9:2]];
  assign seq_pc   = pc_q + 32'd4;

  // Outputs are forced to their reset view while reset is held, not just after the edge.
  assign pc          = reset ? pc_q : RESET_PC;
  assign pc_plus4    = pc + 32'd4;
  assign issue       = (state_q == RUN) && !stall && (rd_word != HALT_WORD);
  assign instr_valid = reset && issue;
  assign instruction = instr_valid ? rd_word : 32'h00000000;
  assign halted      = (state_q == HALT);
  assign fetch_error = fetch_error_q;
  assign fetch_count = count_q;

  always_comb begin
    if (jump)
      target_pc = {seq_pc[31:28], jump_target, 2'b00};
    else if (branch_taken)
      target_pc = seq_pc + (branch_offset << 2);
    else
      target_pc = seq_pc;
    target_bad = (target_pc[1:0] != 2'b00) || ({2'b00, target_pc[31:2]} >= DEPTH_W);
  end

  // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    count_d       = count_q;
    fetch_error_d = fetch_error_q;
    case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN: begin
        if (!stall) begin
          if (rd_word == HALT_WORD) begin
            state_d = HALT;
          end else begin
            count_d = count_q + 32'd1;
            if (target_bad) begin
              fetch_error_d = 1'b1;
              state_d       = HALT;
            end else begin
              pc_d = target_pc;
            end
          end
        end
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      count_q       <= 32'h0;
      fetch_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      count_q       <= count_d;
      fetch_error_q <= fetch_error_d;
    end
  end

  // NOTE: the memory has no reset so a loaded program survives a reset and maps to RAM.
  always_ff @(posedge clk) begin
    if (reset && (state_q == IDLE) && load_en && ({24'h0, load_addr} < DEPTH_W))
      imem[load_addr] <= load_data;
  end

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Directed bench for mips_fetch_unit: sequential fetch, branch, stall, jump priority,
// halt, fetch error and reset recovery against hand-computed values.
module tb_mips_fetch_unit;

  logic        clk;
  logic        reset;
  logic        load_en;
  logic [7:0]  load_addr;
  logic [31:0] load_data;
  logic        start;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_offset;
  logic        jump;
  logic [25:0] jump_target;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] instruction;
  logic        instr_valid;
  logic        halted;
  logic        fetch_error;
  logic [31:0] fetch_count;

  int n_cmp = 0;
  int n_bad = 0;

  mips_fetch_unit dut (
    .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .start(start), .stall(stall), .branch_taken(branch_taken),
    .branch_offset(branch_offset), .jump(jump), .jump_target(jump_target),
    .pc(pc), .pc_plus4(pc_plus4), .instruction(instruction), .instr_valid(instr_valid),
    .halted(halted), .fetch_error(fetch_error), .fetch_count(fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    load_en = 1'b1; load_addr = a; load_data = d;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic fetch_cycle(input string tag, input logic [31:0] exp_pc,
                             input logic [31:0] exp_instr, input logic [31:0] exp_cnt);
    #1;
    check({tag, "_pc"}, pc, exp_pc);
    check({tag, "_instr"}, instruction, exp_instr);
    check({tag, "_valid"}, {31'b0, instr_valid}, 32'd1);
    check({tag, "_cnt"}, fetch_count, exp_cnt);
  endtask

  initial begin
    reset = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0; start = 1'b0;
    stall = 1'b0; branch_taken = 1'b0; branch_offset = '0; jump = 1'b0; jump_target = '0;

    // Reset held for two cycles
    @(negedge clk); #1;
    check("rst_pc", pc, 32'h0);
    check("rst_pc4", pc_plus4, 32'h4);
    check("rst_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_instr", instruction, 32'h0);
    @(negedge clk); #1;
    check("rst_halted", {31'b0, halted}, 32'd0);
    check("rst_cnt", fetch_count, 32'd0);
    check("rst_err", {31'b0, fetch_error}, 32'd0);
    reset = 1'b1;

    load(8'd0, 32'h2001000A);
    load(8'd1, 32'h20020014);
    load(8'd2, 32'h00221820);
    load(8'd3, 32'hFFFFFFFF);
    load(8'd64, 32'h3C01ABCD);

    @(negedge clk); start = 1'b1; #1;
    check("idle_valid", {31'b0, instr_valid}, 32'd0);

    // Sequential fetch; branch back to 4 from pc=8
    @(negedge clk); start = 1'b0;
    fetch_cycle("seq0", 32'h0, 32'h2001000A, 32'd0);
    check("seq0_pc4", pc_plus4, 32'h4);
    @(negedge clk);
    fetch_cycle("seq1", 32'h4, 32'h20020014, 32'd1);
    @(negedge clk); branch_taken = 1'b1; branch_offset = 32'hFFFFFFFE;
    fetch_cycle("seq2", 32'h8, 32'h00221820, 32'd2);

    // Stall two cycles at pc=4 (redirect inputs present but must lose to stall)
    @(negedge clk); stall = 1'b1; #1;
    check("br_pc", pc, 32'h4);
    check("br_cnt", fetch_count, 32'd3);
    check("stall1_valid", {31'b0, instr_valid}, 32'd0);
    check("stall1_instr", instruction, 32'h0);
    @(negedge clk); branch_taken = 1'b0; jump = 1'b1; jump_target = 26'h40; #1;
    check("stall2_pc", pc, 32'h4);
    check("stall2_valid", {31'b0, instr_valid}, 32'd0);

    // Jump and branch together: jump wins
    @(negedge clk); stall = 1'b0; jump = 1'b1; jump_target = 26'h40; branch_taken = 1'b1;
    branch_offset = 32'h00000010;
    fetch_cycle("stall_rel", 32'h4, 32'h20020014, 32'd3);
    @(negedge clk); branch_taken = 1'b0; jump = 1'b1; jump_target = 26'h0;
    fetch_cycle("jmp", 32'h100, 32'h3C01ABCD, 32'd4);

    // Back at 0, run into the halt word; a load attempt in RUN must be ignored
    @(negedge clk); jump = 1'b0; load_en = 1'b1; load_addr = 8'd1; load_data = 32'hDEADBEEF;
    fetch_cycle("run0", 32'h0, 32'h2001000A, 32'd5);
    @(negedge clk); load_en = 1'b0;
    fetch_cycle("run1", 32'h4, 32'h20020014, 32'd6);
    @(negedge clk);
    fetch_cycle("run2", 32'h8, 32'h00221820, 32'd7);
    @(negedge clk); #1;
    check("hw_pc", pc, 32'hC);
    check("hw_valid", {31'b0, instr_valid}, 32'd0);
    check("hw_instr", instruction, 32'h0);
    check("hw_halted", {31'b0, halted}, 32'd0);
    @(negedge clk); start = 1'b1; #1;
    check("halt_halted", {31'b0, halted}, 32'd1);
    check("halt_pc", pc, 32'hC);
    check("halt_cnt", fetch_count, 32'd8);
    @(negedge clk); start = 1'b0; #1;
    check("halt_start_ign", {31'b0, halted}, 32'd1);
    check("halt_start_valid", {31'b0, instr_valid}, 32'd0);

    // Out-of-range jump traps
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0; jump = 1'b1; jump_target = 26'h100;
    fetch_cycle("err_pre", 32'h0, 32'h2001000A, 32'd0);
    @(negedge clk); jump = 1'b0; #1;
    check("err_flag", {31'b0, fetch_error}, 32'd1);
    check("err_halted", {31'b0, halted}, 32'd1);
    check("err_pc", pc, 32'h0);
    check("err_cnt", fetch_count, 32'd1);

    // Reset recovery, memory preserved
    @(negedge clk); reset = 1'b0; #1;
    check("rec_rst_pc", pc, 32'h0);
    @(negedge clk); #1;
    check("rec_err", {31'b0, fetch_error}, 32'd0);
    check("rec_halted", {31'b0, halted}, 32'd0);
    check("rec_cnt", fetch_count, 32'd0);
    reset = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0; jump = 1'b1; jump_target = 26'h40;
    fetch_cycle("rec_fetch", 32'h0, 32'h2001000A, 32'd0);

    // Reset mid-RUN discards the pending jump
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1; jump = 1'b0; #1;
    check("abort_pc", pc, 32'h0);
    check("abort_valid", {31'b0, instr_valid}, 32'd0);
    check("abort_cnt", fetch_count, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mips_fetch_unit.md
MIPS_FETCH_UNIT -- requirements
Module: mips_fetch_unit

Interface
REQ-001 Parameters SHALL be, one per line:
- IMEM_DEPTH, 256, instruction memory depth in 32-bit words.
- RESET_PC, 32'h00000000, PC value after reset; word-aligned.
- HALT_WORD, 32'hFFFFFFFF, instruction encoding that stops fetch.

REQ-002 Ports SHALL be, one per line (all single-bit unless a width is given):
- clk  in  1  sole clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-low (0 = reset).
- load_en  in  1  instruction-memory write strobe.
- load_addr  in  8  word index written.
- load_data  in  32  word written.
- start  in  1  single-cycle pulse; begins fetching.
- stall  in  1  hold PC and output.
- branch_taken  in  1  take branch this cycle.
- branch_offset  in  32  sign-extended word offset.
- jump  in  1  take jump this cycle.
- jump_target  in  26  J-format target field.
- pc  out  32  current fetch address.
- pc_plus4  out  32  pc + 4, modulo 2^32.
- instruction  out  32  word fed to the single-cycle datapath.
- instr_valid  out  1  instruction is issued this cycle.
- halted  out  1  fetch stopped.
- fetch_error  out  1  sticky; illegal fetch target.
- fetch_count  out  32  count of issued instructions.

Function
REQ-003 FSM states SHALL be IDLE, RUN and HALT.
REQ-004 IDLE -> RUN SHALL occur on start=1; start SHALL be ignored in RUN and HALT.
REQ-005 Memory writes (imem[load_addr] <= load_data) SHALL occur only in IDLE; load_en SHALL be ignored in RUN and HALT.
REQ-006 instruction SHALL be a combinational read of imem[pc[9:2]] when instr_valid=1, and 32'h00000000 otherwise.
REQ-007 instr_valid SHALL be 1 only in RUN when stall=0 and the read word != HALT_WORD.
REQ-008 In RUN, next-PC priority SHALL be:
- stall: hold pc.
- jump: next pc = {pc_plus4[31:28], jump_target, 2'b00}.
- branch_taken: next pc = pc_plus4 + (branch_offset << 2), 32-bit wrap.
- otherwise: next pc = pc_plus4.
REQ-009 Latency: a redirect asserted in cycle N SHALL update pc at the edge ending cycle N; the target instruction SHALL appear in cycle N+1.
REQ-010 When RUN reads HALT_WORD with stall=0, the FSM SHALL enter HALT and pc SHALL hold; the halt word SHALL NOT be counted.
REQ-011 A computed next pc that is misaligned (bits[1:0] != 0) or out of range (word index >= IMEM_DEPTH) SHALL set fetch_error=1, enter HALT and leave pc unchanged.
REQ-012 fetch_count SHALL increment by 1 in each cycle with instr_valid=1, wrapping at 2^32.
REQ-013 halted SHALL be 1 exactly in HALT; HALT SHALL be left only via reset.
REQ-014 branch_taken, jump and stall SHALL be ignored outside RUN.

Reset
REQ-015 When reset=0 at a clock edge, the block SHALL set:
- state = IDLE
- pc = RESET_PC
- fetch_count = 0
- fetch_error = 0
- halted = 0
REQ-016 While in reset, outputs SHALL read pc=RESET_PC, pc_plus4=RESET_PC+4, instr_valid=0 and instruction=0.
REQ-017 Memory contents SHALL NOT be cleared by reset.
REQ-018 Reset asserted mid-RUN SHALL abort fetching in the same edge; pending redirect inputs SHALL be discarded.

Verification
REQ-019 The bench SHALL cover these scenarios:
- Reset: reset=0 for 2 cycles -> pc=0, instr_valid=0, halted=0, fetch_count=0.
- Sequential fetch: load imem[0..2] = 0x2001000A, 0x20020014, 0x00221820; pulse start -> cycles 1..3 show pc=0/4/8 with those words, instr_valid=1, fetch_count ends at 3.
- Branch: at pc=8, branch_taken=1, branch_offset=32'hFFFFFFFE -> next pc=4; stall=1 for 2 cycles -> pc holds at 4, instr_valid=0, count unchanged.
- Jump priority: jump=1, jump_target=26'h40 and branch_taken=1 in the same cycle -> next pc=32'h00000100.
- Halt: imem[3]=32'hFFFFFFFF, run sequentially -> at pc=12, instr_valid=0; next cycle halted=1 with pc held at 12; further start ignored.
- Error and reset recovery: jump_target=26'h100 (out of range) -> fetch_error=1, halted=1, pc unchanged; reset -> pc=0, IDLE, memory contents preserved (restart fetches 0x2001000A).
